asrv32_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch stage with a prefetch queue and pipelined Wishbone requests.

---
 rtl/asrv32_fetch_queue.sv | 144 ++++++++++++++
 tb/tb_asrv32_fetch_queue.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asrv32_fetch_queue.sv
// asrv32 instruction fetch: pipelined Wishbone requests tagged with their PCs, a prefetch
// queue for returned words, and the IF/ID register that drains it.
module asrv32_fetch_queue #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_stb_inst,
   output logic [31:0] o_inst_addr,
   input  logic        i_stall_inst,
   input  logic        i_ack_inst,
   input  logic [31:0] i_inst,
   output logic [31:0] o_inst_ifid,
   output logic [31:0] o_pc_ifid,
   input  logic        i_writeback_change_pc,
   input  logic [31:0] i_writeback_next_pc,
   input  logic        i_alu_change_pc,
   input  logic [31:0] i_alu_next_pc,
   output logic        o_ce,
   input  logic        i_stall,
   input  logic        i_flush
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

   logic [31:0] tag_mem    [DEPTH];
   logic [31:0] q_inst_mem [DEPTH];
   logic [31:0] q_pc_mem   [DEPTH];

   logic [31:0] pc_q, pc_d;
   ptr_t        tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   ptr_t        q_wr_q, q_wr_d, q_rd_q, q_rd_d;
   cnt_t        count_q, count_d, out_q, out_d, drop_q, drop_d;
   logic        ce_q, ce_d;
   logic [31:0] inst_ifid_q, inst_ifid_d, pc_ifid_q, pc_ifid_d;

   logic        redirect, accept, ack_ok, ack_keep, ack_drop, pop;
   logic [31:0] target;

   always_comb begin
      redirect = i_writeback_change_pc | i_alu_change_pc;
      target   = i_writeback_change_pc ? i_writeback_next_pc : i_alu_next_pc;
      // Credits cover both buffered words and every in-flight request, so the queue never overflows.
      o_stb_inst = i_rst_n && !redirect && ((count_q + out_q) < DEPTH_C);
      accept     = o_stb_inst && !i_stall_inst;
      ack_ok     = i_ack_inst && (out_q != '0);
      ack_keep   = ack_ok && (drop_q == '0);
      ack_drop   = ack_ok && (drop_q != '0);
      pop        = !i_stall && (count_q != '0);

      pc_d        = pc_q;
      tag_wr_d    = tag_wr_q;
      tag_rd_d    = tag_rd_q;
      q_wr_d      = q_wr_q;
      q_rd_d      = q_rd_q;
      count_d     = count_q + cnt_t'(ack_keep) - cnt_t'(pop);
      out_d       = out_q + cnt_t'(accept) - cnt_t'(ack_ok);
      drop_d      = drop_q - cnt_t'(ack_drop);
      ce_d        = ce_q;
      inst_ifid_d = inst_ifid_q;
      pc_ifid_d   = pc_ifid_q;

      if (accept) begin
         pc_d     = pc_q + 32'd4;
         tag_wr_d = tag_wr_q + ptr_t'(1);
      end
      if (ack_keep) begin
         tag_rd_d = tag_rd_q + ptr_t'(1);
         q_wr_d   = q_wr_q + ptr_t'(1);
      end
      if (!i_stall) begin
         ce_d = (count_q != '0) && !i_flush && !redirect;
         if (pop) begin
            inst_ifid_d = q_inst_mem[q_rd_q];
            pc_ifid_d   = q_pc_mem[q_rd_q];
            q_rd_d      = q_rd_q + ptr_t'(1);
         end
      end

      if (redirect) begin
         pc_d     = target;
         tag_wr_d = '0;
         tag_rd_d = '0;
         q_wr_d   = '0;
         q_rd_d   = '0;
         count_d  = '0;
         // Every request still in flight belongs to the abandoned stream.
         drop_d   = out_q - cnt_t'(ack_ok);
         ce_d     = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) tag_mem[tag_wr_q] <= pc_q;
      if (ack_keep) begin
         q_inst_mem[q_wr_q] <= i_inst;
         q_pc_mem[q_wr_q]   <= tag_mem[tag_rd_q];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pc_q        <= PC_RESET;
         tag_wr_q    <= '0;
         tag_rd_q    <= '0;
         q_wr_q      <= '0;
         q_rd_q      <= '0;
         count_q     <= '0;
         out_q       <= '0;
         drop_q      <= '0;
         ce_q        <= 1'b0;
         inst_ifid_q <= '0;
         pc_ifid_q   <= '0;
      end else begin
         pc_q        <= pc_d;
         tag_wr_q    <= tag_wr_d;
         tag_rd_q    <= tag_rd_d;
         q_wr_q      <= q_wr_d;
         q_rd_q      <= q_rd_d;
         count_q     <= count_d;
         out_q       <= out_d;
         drop_q      <= drop_d;
         ce_q        <= ce_d;
         inst_ifid_q <= inst_ifid_d;
         pc_ifid_q   <= pc_ifid_d;
      end
   end

   assign o_inst_addr = pc_q;
   assign o_ce        = ce_q;
   assign o_inst_ifid = inst_ifid_q;
   assign o_pc_ifid   = pc_ifid_q;

   // An ack with nothing outstanding is a bus error; the logic above ignores it.
   ack_needs_request: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_ack_inst |-> (out_q != '0));

endmodule

// File: tb/tb_asrv32_fetch_queue.sv
// Bench for asrv32_fetch_queue: in-order memory model with random latency/stall and an
// instruction-stream scoreboard (expected PC sequence, instruction word derived from PC).
module tb_asrv32_fetch_queue;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] PC_RESET = 32'h0000_0000;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        o_stb_inst;
   logic [31:0] o_inst_addr;
   logic        i_stall_inst = 1'b0;
   logic        i_ack_inst = 1'b0;
   logic [31:0] i_inst = '0;
   logic [31:0] o_inst_ifid;
   logic [31:0] o_pc_ifid;
   logic        i_writeback_change_pc = 1'b0;
   logic [31:0] i_writeback_next_pc = '0;
   logic        i_alu_change_pc = 1'b0;
   logic [31:0] i_alu_next_pc = '0;
   logic        o_ce;
   logic        i_stall = 1'b0;
   logic        i_flush = 1'b0;

   asrv32_fetch_queue #(.PC_RESET(PC_RESET), .DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .o_stb_inst(o_stb_inst), .o_inst_addr(o_inst_addr), .i_stall_inst(i_stall_inst),
      .i_ack_inst(i_ack_inst), .i_inst(i_inst),
      .o_inst_ifid(o_inst_ifid), .o_pc_ifid(o_pc_ifid),
      .i_writeback_change_pc(i_writeback_change_pc), .i_writeback_next_pc(i_writeback_next_pc),
      .i_alu_change_pc(i_alu_change_pc), .i_alu_next_pc(i_alu_next_pc),
      .o_ce(o_ce), .i_stall(i_stall), .i_flush(i_flush)
   );

   always #5 i_clk = ~i_clk;

   int          tests = 0;
   int          fails = 0;
   int unsigned cyc = 0;
   logic [31:0] mem_addr_q[$];
   int unsigned mem_due_q[$];
   int unsigned lat_max = 1;
   int unsigned stall_inst_pct = 0;
   bit          hold_en = 1'b0;
   logic [31:0] hold_lo = '0, hold_hi = '0;
   bit          force_stall_inst = 1'b0;
   logic [31:0] exp_pc = PC_RESET;
   bit          chk_en = 1'b1;
   int          n_stale = 0;
   logic [31:0] got_pc[$];
   logic [31:0] acc_addr[$];
   bit          prev_held = 1'b0;
   logic [31:0] prev_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   // One clock: memory response, bus acceptance, scoreboard update, IF/ID check.
   task automatic tick();
      logic        ce_now, redir, acc;
      logic [31:0] tgt, pc_now;
      i_ack_inst = 1'b0;
      i_inst     = 32'h0bad_0bad;
      if (mem_addr_q.size() != 0 && mem_due_q[0] <= cyc &&
          !(hold_en && mem_addr_q[0] >= hold_lo && mem_addr_q[0] <= hold_hi)) begin
         i_ack_inst = 1'b1;
         i_inst     = mem_word(mem_addr_q[0]);
         void'(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
         if (n_stale > 0) n_stale--;
      end
      i_stall_inst = force_stall_inst || ($urandom_range(99) < stall_inst_pct);
      #1;
      redir  = i_writeback_change_pc || i_alu_change_pc;
      tgt    = i_writeback_change_pc ? i_writeback_next_pc : i_alu_next_pc;
      ce_now = o_ce;
      pc_now = o_pc_ifid;
      if (redir) begin
         tests++;
         if (o_stb_inst !== 1'b0) begin
            fails++;
            $display("FAIL stb_in_redirect: o_stb_inst=%b required 0", o_stb_inst);
         end
      end
      if (prev_held && !redir) begin
         tests++;
         if (o_stb_inst !== 1'b1 || o_inst_addr !== prev_addr) begin
            fails++;
            $display("FAIL hold_under_stall: stb=%b addr=%h required stb=1 addr=%h",
                     o_stb_inst, o_inst_addr, prev_addr);
         end
      end
      acc       = o_stb_inst && !i_stall_inst;
      prev_held = o_stb_inst && i_stall_inst;
      prev_addr = o_inst_addr;
      if (acc) begin
         mem_addr_q.push_back(o_inst_addr);
         mem_due_q.push_back(cyc + $urandom_range(lat_max, 1));
         acc_addr.push_back(o_inst_addr);
         tests++;
         if (mem_addr_q.size() > DEPTH) begin
            fails++;
            $display("FAIL outstanding_limit: in flight %0d required <= %0d",
                     mem_addr_q.size(), DEPTH);
         end
      end
      @(posedge i_clk);
      cyc++;
      if (ce_now && !i_stall) begin
         got_pc.push_back(pc_now);
         exp_pc = exp_pc + 32'd4;
      end
      if (i_flush && !i_stall) chk_en = 1'b0;
      if (redir) begin
         exp_pc  = tgt;
         chk_en  = 1'b1;
         n_stale = mem_addr_q.size();
      end
      @(negedge i_clk);
      if (o_ce === 1'b1 && chk_en) begin
         tests++;
         if (o_pc_ifid !== exp_pc || o_inst_ifid !== mem_word(exp_pc)) begin
            fails++;
            $display("FAIL ifid_stream: pc=%h inst=%h required pc=%h inst=%h",
                     o_pc_ifid, o_inst_ifid, exp_pc, mem_word(exp_pc));
         end
      end
      i_writeback_change_pc = 1'b0;
      i_alu_change_pc       = 1'b0;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      i_ack_inst = 1'b0; i_stall_inst = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
      i_writeback_change_pc = 1'b0; i_alu_change_pc = 1'b0;
      mem_addr_q.delete(); mem_due_q.delete(); got_pc.delete(); acc_addr.delete();
      n_stale = 0; prev_held = 1'b0; chk_en = 1'b1; exp_pc = PC_RESET;
      hold_en = 1'b0; force_stall_inst = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      tests++;
      if (o_stb_inst !== 1'b0 || o_ce !== 1'b0 || o_inst_addr !== PC_RESET ||
          o_inst_ifid !== 32'h0 || o_pc_ifid !== 32'h0) begin
         fails++;
         $display("FAIL reset_values: stb=%b ce=%b addr=%h inst=%h pc=%h required 0 0 %h 0 0",
                  o_stb_inst, o_ce, o_inst_addr, o_inst_ifid, o_pc_ifid, PC_RESET);
      end
      i_rst_n = 1'b1;
      #1;
      tests++;
      if (o_stb_inst !== 1'b1 || o_inst_addr !== PC_RESET) begin
         fails++;
         $display("FAIL first_request: stb=%b addr=%h required 1 %h",
                  o_stb_inst, o_inst_addr, PC_RESET);
      end
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (o_ce !== 1'b0) begin
         fails++;
         $display("FAIL ce_after_reset: o_ce=%b required 0", o_ce);
      end
   endtask

   task automatic test_stream();
      do_reset();
      lat_max = 1; stall_inst_pct = 0;
      for (int t = 1; t <= 24; t++) begin
         tick();
         tests++;
         if (o_ce !== (t >= 3)) begin
            fails++;
            $display("FAIL stream_ce t=%0d: o_ce=%b required %b", t, o_ce, (t >= 3));
         end
      end
      tests++;
      if (got_pc.size() != 21 || got_pc[20] !== 32'd80) begin
         fails++;
         $display("FAIL stream_count: delivered %0d required 21", got_pc.size());
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      lat_max = 1; stall_inst_pct = 0; i_stall = 1'b1;
      repeat (10) tick();
      tests++;
      if (acc_addr.size() != DEPTH || o_stb_inst !== 1'b0 || o_ce !== 1'b0) begin
         fails++;
         $display("FAIL bp_issue: requests=%0d stb=%b ce=%b required %0d 0 0",
                  acc_addr.size(), o_stb_inst, o_ce, DEPTH);
      end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (k >= acc_addr.size() || acc_addr[k] !== 32'(4 * k)) begin
            fails++;
            $display("FAIL bp_req_addr[%0d]: required %h", k, 32'(4 * k));
         end
      end
      i_stall = 1'b0;
      repeat (8) tick();
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (k >= got_pc.size() || got_pc[k] !== 32'(4 * k)) begin
            fails++;
            $display("FAIL bp_drain[%0d]: delivered %0d entries, required pc %h",
                     k, got_pc.size(), 32'(4 * k));
         end
      end
   endtask

   task automatic test_stale_drop();
      int idx;
      do_reset();
      lat_max = 1; stall_inst_pct = 0;
      hold_en = 1'b1; hold_lo = 32'h10; hold_hi = 32'h14;
      for (int g = 0; g < 40 && o_inst_addr !== 32'h18; g++) tick();
      tests++;
      if (o_inst_addr !== 32'h18 || mem_addr_q.size() != 2) begin
         fails++;
         $display("FAIL stale_setup: addr=%h in flight %0d required 18 and 2",
                  o_inst_addr, mem_addr_q.size());
      end
      force_stall_inst = 1'b1;
      repeat (3) tick();
      i_alu_change_pc = 1'b1; i_alu_next_pc = 32'h100;
      tick();
      idx = got_pc.size();
      force_stall_inst = 1'b0;
      repeat (2) tick();
      hold_en = 1'b0;
      repeat (12) tick();
      tests++;
      if (got_pc.size() <= idx || got_pc[idx] !== 32'h100) begin
         fails++;
         $display("FAIL stale_first_pc: delivered %0d after redirect, required first pc 100",
                  got_pc.size() - idx);
      end
   endtask

   task automatic test_priority();
      int idx;
      bit bad;
      lat_max = 3; stall_inst_pct = 0; i_stall = 1'b0;
      i_writeback_change_pc = 1'b1; i_writeback_next_pc = 32'h80;
      i_alu_change_pc = 1'b1; i_alu_next_pc = 32'h200;
      tick();
      idx = got_pc.size();
      tests++;
      if (o_inst_addr !== 32'h80) begin
         fails++;
         $display("FAIL prio_addr: o_inst_addr=%h required 80", o_inst_addr);
      end
      repeat (20) tick();
      bad = (got_pc.size() <= idx);
      for (int k = idx; k < got_pc.size(); k++)
         if (got_pc[k] !== 32'h80 + 32'(4 * (k - idx))) bad = 1'b1;
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL prio_stream: %0d delivered, required contiguous from 80",
                  got_pc.size() - idx);
      end
   endtask

   task automatic test_flush_stall();
      int idx;
      logic [31:0] pc_hold;
      lat_max = 1; stall_inst_pct = 0; i_stall = 1'b0;
      repeat (6) tick();
      tests++;
      if (o_ce !== 1'b1) begin
         fails++;
         $display("FAIL flush_setup: o_ce=%b required 1", o_ce);
      end
      pc_hold = o_pc_ifid;
      i_stall = 1'b1; i_flush = 1'b1;
      tick();
      tests++;
      if (o_ce !== 1'b1 || o_pc_ifid !== pc_hold) begin
         fails++;
         $display("FAIL flush_while_stalled: ce=%b pc=%h required 1 %h", o_ce, o_pc_ifid, pc_hold);
      end
      i_stall = 1'b0;
      tick();
      tests++;
      if (o_ce !== 1'b0) begin
         fails++;
         $display("FAIL flush_kills: o_ce=%b required 0", o_ce);
      end
      i_flush = 1'b0;
      i_alu_change_pc = 1'b1; i_alu_next_pc = 32'hffff_fff8;
      tick();
      idx = got_pc.size();
      repeat (12) tick();
      tests++;
      if (got_pc.size() < idx + 3 || got_pc[idx] !== 32'hffff_fff8 ||
          got_pc[idx+1] !== 32'hffff_fffc || got_pc[idx+2] !== 32'h0) begin
         fails++;
         $display("FAIL pc_wrap: delivered %0d, required fffffff8 fffffffc 00000000",
                  got_pc.size() - idx);
      end
   endtask

   task automatic test_midop_reset();
      lat_max = 2; stall_inst_pct = 0; i_stall = 1'b0;
      repeat (5) tick();
      do_reset();
      lat_max = 1;
      repeat (8) tick();
      tests++;
      if (got_pc.size() == 0 || got_pc[0] !== PC_RESET) begin
         fails++;
         $display("FAIL restart_after_reset: delivered %0d, required first pc %h",
                  got_pc.size(), PC_RESET);
      end
   endtask

   task automatic test_random();
      int unsigned r;
      logic [31:0] tgt;
      do_reset();
      lat_max = 4; stall_inst_pct = 30;
      for (int c = 0; c < 3000; c++) begin
         i_stall = ($urandom_range(99) < 25);
         i_flush = ($urandom_range(99) < 2);
         if (n_stale == 0 && (!chk_en || $urandom_range(99) < 4)) begin
            r   = $urandom_range(2);
            tgt = ($urandom_range(9) == 0) ? 32'hffff_fff0 : ($urandom & 32'hffff_fffc);
            i_writeback_change_pc = (r != 1);
            i_alu_change_pc       = (r != 0);
            i_writeback_next_pc   = tgt;
            i_alu_next_pc         = tgt ^ 32'h0000_4000;
         end
         tick();
      end
      i_stall = 1'b0; i_flush = 1'b0;
      tests++;
      if (got_pc.size() < 300) begin
         fails++;
         $display("FAIL random_progress: delivered %0d required >= 300", got_pc.size());
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_stale_drop();
      test_priority();
      test_flush_stall();
      test_midop_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
